// File: rtl/shift_sequencer_pkg.sv
// Shared types for the shift sequencer: FSM state encoding and counter width.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETTLE = 2'b01,
    SHIFT  = 2'b10,
    DONE   = 2'b11
  } state_t;

  localparam int CNT_W = 4;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/grant and shift-control signals between the sequencer and its requesters.
interface shift_sequencer_if;

  logic [1:0] req;
  logic       Sample_Enable;
  logic [1:0] gnt;
  logic       RShift;
  logic       busy;
  logic       done;
  logic [1:0] st;
`ifdef SHIFT_SEQ_TIMEOUT_EN
  logic       timeout;

  modport master (output req, Sample_Enable, input gnt, RShift, busy, done, st, timeout);
  modport slave  (input req, Sample_Enable, output gnt, RShift, busy, done, st, timeout);
`else
  modport master (output req, Sample_Enable, input gnt, RShift, busy, done, st);
  modport slave  (input req, Sample_Enable, output gnt, RShift, busy, done, st);
`endif

endinterface

// File: rtl/shift_sequencer_rr_arb2.sv
// Two-way round-robin pick, purely combinational: one-hot winner, zero when no request.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  output logic [1:0] o_win
);

  // i_ptr names the requester that wins a tie
  always_comb begin
    o_win = 2'b00;
    case (i_req)
      2'b01:   o_win = 2'b01;
      2'b10:   o_win = 2'b10;
      2'b11:   o_win = i_ptr ? 2'b10 : 2'b01;
      default: o_win = 2'b00;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Arbitrates two requesters and issues FRAME_BITS shift pulses per granted frame on baud ticks.
// Grant registers one edge after req; optional watchdog abort under macro SHIFT_SEQ_TIMEOUT_EN.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int FRAME_BITS   = 10,
  parameter int SETTLE_TICKS = 1,
  parameter int TIMEOUT_CYC  = 255
) (
  input logic              clk,
  input logic              rst_n,
  shift_sequencer_if.slave bus
);

  if (FRAME_BITS < 1 || FRAME_BITS > 15 || SETTLE_TICKS < 0 || SETTLE_TICKS > 15 ||
      TIMEOUT_CYC < 1) begin : g_bad_params
    $error("shift_sequencer: parameter out of range");
  end

  state_t           r_state, w_next;
  logic [1:0]       r_gnt, w_gnt_nxt, w_win;
  logic             r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0] r_tick, w_tick_nxt;
  logic [CNT_W-1:0] r_bits, w_bits_nxt;
  logic             w_shift;
  logic             w_abort;

  rr_arb2 u_arb (
    .i_req (bus.req),
    .i_ptr (r_ptr),
    .o_win (w_win)
  );

  // Gated by rst_n so a tick arriving during reset never reaches the shift register
  assign w_shift = rst_n && (r_state == SHIFT) && bus.Sample_Enable;

`ifdef SHIFT_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] r_wd;

  // Held at zero in IDLE, so it starts fresh whenever a frame begins
  always_ff @(posedge clk) begin
    if (!rst_n || r_state == IDLE || bus.Sample_Enable) begin
      r_wd <= '0;
    end else if (r_wd != WD_W'(TIMEOUT_CYC)) begin
      r_wd <= r_wd + 1'b1;
    end
  end

  assign w_abort     = ((r_state == SETTLE) || (r_state == SHIFT)) && (r_wd == WD_W'(TIMEOUT_CYC));
  assign bus.timeout = w_abort;
`else
  assign w_abort = 1'b0;
`endif

  always_comb begin
    w_next     = r_state;
    w_gnt_nxt  = r_gnt;
    w_ptr_nxt  = r_ptr;
    w_tick_nxt = r_tick;
    w_bits_nxt = r_bits;
    case (r_state)
      IDLE: begin
        w_tick_nxt = '0;
        w_bits_nxt = '0;
        if (bus.req != 2'b00) begin
          w_gnt_nxt = w_win;
          w_next    = (SETTLE_TICKS == 0) ? SHIFT : SETTLE;
        end
      end
      SETTLE: begin
        if (bus.Sample_Enable) begin
          w_tick_nxt = r_tick + 1'b1;
          if (w_tick_nxt == CNT_W'(SETTLE_TICKS)) begin
            w_next     = SHIFT;
            w_bits_nxt = '0;
          end
        end
      end
      SHIFT: begin
        if (w_shift) begin
          w_bits_nxt = r_bits + 1'b1;
          if (w_bits_nxt == CNT_W'(FRAME_BITS)) begin
            w_next = DONE;
          end
        end
      end
      DONE: begin
        w_next    = IDLE;
        w_gnt_nxt = 2'b00;
        w_ptr_nxt = r_gnt[0];
      end
      default: w_next = IDLE;
    endcase
    // Abort hands the tie-break to the other requester just like a finished frame
    if (w_abort) begin
      w_next    = IDLE;
      w_gnt_nxt = 2'b00;
      w_ptr_nxt = r_gnt[0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= 2'b00;
      r_ptr   <= 1'b0;
      r_tick  <= '0;
      r_bits  <= '0;
    end else begin
      r_state <= w_next;
      r_gnt   <= w_gnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_tick  <= w_tick_nxt;
      r_bits  <= w_bits_nxt;
    end
  end

  assign bus.gnt    = r_gnt;
  assign bus.RShift = w_shift;
  assign bus.busy   = (r_state != IDLE);
  assign bus.done   = (r_state == DONE);
  assign bus.st     = r_state;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: default-parameter instance plus a FRAME_BITS=1/SETTLE_TICKS=0 instance.
module tb_shift_sequencer;

  localparam logic [31:0] G0 = 32'd1;  // gnt = 01
  localparam logic [31:0] G1 = 32'd2;  // gnt = 10

  logic clk = 1'b0;
  logic rst_n;

  shift_sequencer_if m_if ();
  shift_sequencer_if e_if ();

  shift_sequencer #(.FRAME_BITS(10), .SETTLE_TICKS(1), .TIMEOUT_CYC(20)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m_if)
  );

  shift_sequencer #(.FRAME_BITS(1), .SETTLE_TICKS(0), .TIMEOUT_CYC(255)) u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (e_if)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int phase = 0;

  logic s_rs, s_dn, s_to, s_tick;

  logic [1:0] f_gnt;
  int         f_pulses, f_dones, f_idle, f_first, f_gap, f_touts;
  bit         f_stable, f_ended;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive the tick, sample outputs mid-cycle, then advance past the edge
  task automatic step(input logic se);
    m_if.Sample_Enable = se;
    @(negedge clk);
    s_rs   = m_if.RShift;
    s_dn   = m_if.done;
    s_tick = se && m_if.busy;
`ifdef SHIFT_SEQ_TIMEOUT_EN
    s_to   = m_if.timeout;
`else
    s_to   = 1'b0;
`endif
    @(posedge clk);
    #1;
  endtask

  // Sample_Enable once every 4 clocks
  task automatic step_auto();
    step(phase == 0);
    phase = (phase + 1) % 4;
  endtask

  // Runs from IDLE until the DUT has been busy and has returned to IDLE
  task automatic run_frame(input int drop_at);
    int  ticks, last_rs;
    bit  started;
    f_gnt = 2'b00; f_pulses = 0; f_dones = 0; f_idle = 0; f_first = 0; f_gap = -1;
    f_touts = 0; f_stable = 1'b1; f_ended = 1'b0;
    started = 1'b0; ticks = 0; last_rs = 0;
    for (int idx = 1; idx <= 400; idx++) begin
      step_auto();
      if (s_tick) ticks++;
      if (s_rs) begin
        f_pulses++;
        last_rs = idx;
        if (f_pulses == 1) f_first = ticks;
      end
      if (s_dn) begin
        f_dones++;
        f_gap = idx - last_rs;
      end
      if (s_to) f_touts++;
      if (drop_at != 0 && f_pulses == drop_at) m_if.req = 2'b00;
      if (!started) begin
        f_idle++;
        if (m_if.st != 2'b00) begin
          started = 1'b1;
          f_gnt   = m_if.gnt;
        end
      end else if (m_if.st == 2'b00) begin
        f_ended = 1'b1;
        break;
      end else if (m_if.gnt != f_gnt) begin
        f_stable = 1'b0;
      end
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] exp_g [4];
    int         cnt;

    rst_n = 1'b0;
    m_if.req = 2'b00; m_if.Sample_Enable = 1'b0;
    e_if.req = 2'b00; e_if.Sample_Enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_st",   32'(m_if.st),   0);
    chk("rst_gnt",  32'(m_if.gnt),  0);
    chk("rst_busy", 32'(m_if.busy), 0);
    chk("rst_done", 32'(m_if.done), 0);
    rst_n = 1'b1;
    step(1'b0);

    // Contention from reset: req[0] wins first, then strict alternation
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    m_if.req = 2'b11;
    for (int f = 0; f < 4; f++) begin
      run_frame(0);
      chk("rr_end",    32'(f_ended),  1);
      chk("rr_gnt",    32'(f_gnt),    32'(exp_g[f]));
      chk("rr_pulses", 32'(f_pulses), 10);
      chk("rr_done",   32'(f_dones),  1);
      chk("rr_gap",    32'(f_idle),   1);
      chk("rr_stable", 32'(f_stable), 1);
    end
    m_if.req = 2'b00;
    step_auto();

    // Single frame: one settle tick skipped, done the cycle after the 10th pulse
    m_if.req = 2'b01;
    run_frame(0);
    m_if.req = 2'b00;
    chk("sf_end",     32'(f_ended),  1);
    chk("sf_gnt",     32'(f_gnt),    G0);
    chk("sf_pulses",  32'(f_pulses), 10);
    chk("sf_first",   32'(f_first),  2);
    chk("sf_done",    32'(f_dones),  1);
    chk("sf_donegap", 32'(f_gap),    1);
    chk("sf_gnt_end", 32'(m_if.gnt), 0);
    chk("sf_st_end",  32'(m_if.st),  0);
    step_auto();
    chk("sf_stay_idle", 32'(m_if.st), 0);

    // Request dropped after the 3rd pulse: frame still completes
    m_if.req = 2'b01;
    run_frame(3);
    chk("drop_end",    32'(f_ended),  1);
    chk("drop_gnt",    32'(f_gnt),    G0);
    chk("drop_pulses", 32'(f_pulses), 10);
    chk("drop_done",   32'(f_dones),  1);
    step_auto();
    chk("drop_idle", 32'(m_if.st), 0);

    // Reset for one clock right after the 5th pulse, with a tick present during reset
    m_if.req = 2'b01;
    cnt = 0;
    for (int i = 0; i < 200 && cnt < 5; i++) begin
      step_auto();
      if (s_rs) cnt++;
    end
    chk("mrst_pre", 32'(cnt), 5);
    chk("mrst_st_pre", 32'(m_if.st), 2);
    m_if.req = 2'b00;
    rst_n = 1'b0;
    step(1'b1);
    rst_n = 1'b1;
    chk("mrst_rs_in_rst", 32'(s_rs),      0);
    chk("mrst_st",        32'(m_if.st),   0);
    chk("mrst_gnt",       32'(m_if.gnt),  0);
    chk("mrst_done",      32'(m_if.done), 0);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step_auto();
      if (s_rs) cnt++;
    end
    chk("mrst_no_rs", 32'(cnt), 0);
    m_if.req = 2'b10;
    run_frame(0);
    m_if.req = 2'b00;
    chk("mrst2_end",    32'(f_ended),  1);
    chk("mrst2_gnt",    32'(f_gnt),    G1);
    chk("mrst2_pulses", 32'(f_pulses), 10);
    chk("mrst2_done",   32'(f_dones),  1);
    step_auto();

    // FRAME_BITS=1, SETTLE_TICKS=0: grant goes straight to SHIFT, one pulse, done
    e_if.req = 2'b01;
    @(posedge clk); #1;
    e_if.req = 2'b00;
    chk("edge_st_shift", 32'(e_if.st),  2);
    chk("edge_gnt",      32'(e_if.gnt), G0);
    e_if.Sample_Enable = 1'b1;
    @(negedge clk);
    chk("edge_rs", 32'(e_if.RShift), 1);
    @(posedge clk); #1;
    e_if.Sample_Enable = 1'b0;
    chk("edge_st_done", 32'(e_if.st),   3);
    chk("edge_done",    32'(e_if.done), 1);
    @(negedge clk);
    chk("edge_rs_done", 32'(e_if.RShift), 0);
    @(posedge clk); #1;
    chk("edge_st_idle", 32'(e_if.st),   0);
    chk("edge_gnt_end", 32'(e_if.gnt),  0);
    chk("edge_done_end", 32'(e_if.done), 0);

`ifdef SHIFT_SEQ_TIMEOUT_EN
    // Ticks stop after the 4th pulse: abort 20 clocks after that last tick
    m_if.req = 2'b01;
    cnt = 0;
    for (int i = 0; i < 200 && cnt < 4; i++) begin
      step_auto();
      if (s_rs) cnt++;
    end
    m_if.req = 2'b00;
    chk("to_pre", 32'(cnt), 4);
    cnt = 0;
    f_dones = 0;
    for (int i = 0; i < 60; i++) begin
      step(1'b0);
      if (s_dn) f_dones++;
      if (s_to) break;
      cnt++;
    end
    chk("to_delay", 32'(cnt),      20);
    chk("to_nodone", 32'(f_dones), 0);
    chk("to_st",    32'(m_if.st),  0);
    chk("to_gnt",   32'(m_if.gnt), 0);
    step(1'b0);
    chk("to_pulse_width", 32'(s_to), 0);
    chk("to_no_done2",    32'(s_dn), 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have parameter FRAME_BITS, default 10, giving RShift pulses per frame (legal range 1..15).
REQ-002 SHALL have parameter SETTLE_TICKS, default 1, giving Sample_Enable ticks skipped after grant before the first shift (legal range 0..15).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 255, giving the watchdog limit in clk cycles (used only with the macro).
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 Ports: clk  in  1  rising-edge clock.
REQ-006 Ports: rst_n  in  1  synchronous active-low reset.
REQ-007 Ports: req  in  2  per-requester frame request, level.
REQ-008 Ports: Sample_Enable  in  1  baud tick, one clk wide.
REQ-009 Ports: gnt  out  2  one-hot registered grant, all-zero when idle.
REQ-010 Ports: RShift  out  1  shift pulse to the shared shift register.
REQ-011 Ports: busy  out  1  high in every state except IDLE.
REQ-012 Ports: done  out  1  one-cycle frame-complete pulse.
REQ-013 Ports: st  out  2  current state encoding.
REQ-014 Ports: timeout  out  1  one-cycle abort pulse; present only with the macro.

Function
REQ-015 SHALL implement states IDLE=00, SETTLE=01, SHIFT=10, DONE=11, all registered.
REQ-016 In IDLE with req!=0, SHALL register gnt to the winner and go to SETTLE on the next edge. If SETTLE_TICKS==0 it SHALL go directly to SHIFT.
REQ-017 Arbitration SHALL be round-robin. When both requests are active, the requester not served last wins. After reset, req[0] has priority.
REQ-018 In SETTLE, SHALL count Sample_Enable ticks and enter SHIFT on the edge where the count reaches SETTLE_TICKS.
REQ-019 RShift SHALL be combinational: state==SHIFT and Sample_Enable. It is never asserted in any other state.
REQ-020 The bit counter SHALL be 4 bits wide and cleared on entry to SHIFT. It SHALL increment on every RShift.
REQ-021 On the RShift that makes count==FRAME_BITS, SHALL enter DONE. Exactly FRAME_BITS pulses are issued per frame.
REQ-022 DONE SHALL last one cycle with done=1. On exit it SHALL clear gnt, update the round-robin pointer and return to IDLE.
REQ-023 gnt SHALL remain stable from SETTLE through DONE. Deassertion of req mid-frame SHALL be ignored and the frame completes.
REQ-024 A req held through DONE SHALL be considered again in IDLE. The minimum gap between frames is one IDLE cycle.
REQ-025 Sample_Enable in IDLE or DONE SHALL have no effect.

Reset
REQ-026 With rst_n=0 at a clk edge, SHALL set the following regardless of state, including mid-frame: state=IDLE, gnt=00, counters=0, pointer favouring req[0], done=0 and timeout=0.
REQ-027 RShift SHALL be 0 while in reset.

Configuration
REQ-028 Macro SHIFT_SEQ_TIMEOUT_EN, when defined, SHALL add a cycle counter that clears on every Sample_Enable and on entry to SETTLE.
REQ-029 With SHIFT_SEQ_TIMEOUT_EN defined, when that counter reaches TIMEOUT_CYC in SETTLE or SHIFT, SHALL pulse timeout for one cycle, clear gnt, rotate the pointer and go to IDLE, with no done.
REQ-030 Without SHIFT_SEQ_TIMEOUT_EN, the timeout port, counter and abort path SHALL be absent, and the block waits indefinitely.

Structure
REQ-031 Package shift_seq_pkg SHALL hold the state typedef and the encodings IDLE, SETTLE, SHIFT and DONE.
REQ-032 Round-robin selection SHALL be the sub-module rr_arb2 (inputs req, pointer; output one-hot winner).

Verification
REQ-033 Single frame: req=01, Sample_Enable every 4 clks, defaults -> gnt=01; 1 tick skipped; 10 RShift pulses; done one cycle after the 10th; gnt=00.
REQ-034 Contention: req=11 held -> frames granted 01, 10, 01, 10. Each frame has exactly 10 pulses, with one IDLE cycle between frames.
REQ-035 Request drop: req[0] deasserted after the 3rd RShift -> frame still completes with 10 pulses and done.
REQ-036 Mid-frame reset: rst_n=0 for 1 clk after the 5th pulse -> st=00, gnt=00, no further RShift; the next req=10 is granted with the full 10 pulses.
REQ-037 Timeout (macro on, TIMEOUT_CYC=20): Sample_Enable stopped after the 4th pulse -> timeout pulses exactly 20 clks after the last tick; no done; st=00.
REQ-038 Edge parameters: FRAME_BITS=1, SETTLE_TICKS=0 -> first tick after grant yields one RShift, then done.
